// File: rtl/scope_pkg.sv
// Shared types and default widths for the scope capture path and the HDMI frame writer.
package scope_pkg;

    localparam int ADC_RES_DEF = 12;
    localparam int VAL_RES_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREARM  = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/trig_detect.sv
// Saturating hysteresis band around the trigger level, plus the slope-selected
// pre-arm and trigger comparators for the current sample.
module trig_detect
    import scope_pkg::*;
#(
    parameter int ADC_RES = ADC_RES_DEF
) (
    input  logic [ADC_RES-1:0] sample,
    input  logic [ADC_RES-1:0] level,
    input  logic [ADC_RES-1:0] hyst,
    input  logic               slope,
    output logic               prearm_ok,
    output logic               trig_ok
);

    logic [ADC_RES:0]   diff;
    logic [ADC_RES:0]   sum;
    logic [ADC_RES-1:0] lo;
    logic [ADC_RES-1:0] hi;

    always_comb begin
        diff = {1'b0, level} - {1'b0, hyst};
        sum  = {1'b0, level} + {1'b0, hyst};
        // The extra top bit flags a borrow (below zero) or a carry (above full scale).
        lo = diff[ADC_RES] ? '0 : diff[ADC_RES-1:0];
        hi = sum[ADC_RES] ? {ADC_RES{1'b1}} : sum[ADC_RES-1:0];
        prearm_ok = slope ? (sample >= hi) : (sample <= lo);
        trig_ok   = slope ? (sample <= level) : (sample >= level);
    end

endmodule

// File: rtl/scope_trigger_capture.sv
// Arms on request, waits for a hysteresis-qualified edge (or an auto timeout),
// then emits one decimated sample per display column.
module scope_trigger_capture
    import scope_pkg::*;
#(
    parameter int ADC_RES      = ADC_RES_DEF,
    parameter int VAL_RES      = VAL_RES_DEF,
    parameter int DECIM_W      = 16,
    parameter int COL_W        = 10,
    parameter int AUTO_TIMEOUT = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADC_RES-1:0] adc_data,
    input  logic               adc_valid,
    input  logic               arm,
    input  logic [ADC_RES-1:0] trig_level,
    input  logic [ADC_RES-1:0] trig_hyst,
    input  logic               trig_slope,
    input  logic               auto_mode,
    input  logic [DECIM_W-1:0] decim,
    input  logic [COL_W-1:0]   num_cols,
    output logic [VAL_RES-1:0] val,
    output logic               val_valid,
    output logic               capture_done,
    output logic               busy,
    output logic               auto_trig
);

    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(AUTO_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_SAT  = TO_W'(AUTO_TIMEOUT);

    state_t             state;
    logic [ADC_RES-1:0] level_q;
    logic [ADC_RES-1:0] hyst_q;
    logic               slope_q;
    logic               auto_q;
    logic [DECIM_W-1:0] decim_m1;
    logic [COL_W-1:0]   cols_m1;
    logic [DECIM_W-1:0] skip_cnt;
    logic [COL_W-1:0]   col_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic               prearm_ok;
    logic               trig_ok;
    logic               real_hit;
    logic               forced_hit;

    trig_detect #(
        .ADC_RES (ADC_RES)
    ) u_trig_detect (
        .sample    (adc_data),
        .level     (level_q),
        .hyst      (hyst_q),
        .slope     (slope_q),
        .prearm_ok (prearm_ok),
        .trig_ok   (trig_ok)
    );

    // A real edge outranks a simultaneous timeout, so auto_trig only reflects pure timeouts.
    assign real_hit   = (state == S_WAIT) && trig_ok;
    assign forced_hit = auto_q && (to_cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            level_q      <= '0;
            hyst_q       <= '0;
            slope_q      <= 1'b0;
            auto_q       <= 1'b0;
            decim_m1     <= '0;
            cols_m1      <= '0;
            skip_cnt     <= '0;
            col_cnt      <= '0;
            to_cnt       <= '0;
            val          <= '0;
            val_valid    <= 1'b0;
            capture_done <= 1'b0;
            busy         <= 1'b0;
            auto_trig    <= 1'b0;
        end else begin
            val_valid    <= 1'b0;
            capture_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arm) begin
                        level_q  <= trig_level;
                        hyst_q   <= trig_hyst;
                        slope_q  <= trig_slope;
                        auto_q   <= auto_mode;
                        decim_m1 <= (decim == '0) ? '0 : decim - DECIM_W'(1);
                        cols_m1  <= (num_cols == '0) ? '0 : num_cols - COL_W'(1);
                        skip_cnt <= '0;
                        col_cnt  <= '0;
                        to_cnt   <= '0;
                        busy     <= 1'b1;
                        state    <= S_PREARM;
                    end
                end
                S_PREARM, S_WAIT: begin
                    if (adc_valid) begin
                        if (to_cnt != TO_SAT) begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                        if (real_hit || forced_hit) begin
                            // The triggering sample itself is column 0.
                            auto_trig <= !real_hit;
                            val       <= VAL_RES'(adc_data);
                            val_valid <= 1'b1;
                            skip_cnt  <= decim_m1;
                            col_cnt   <= COL_W'(1);
                            state     <= (cols_m1 == '0) ? S_DONE : S_CAPTURE;
                        end else if (state == S_PREARM && prearm_ok) begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (adc_valid) begin
                        if (skip_cnt == '0) begin
                            val       <= VAL_RES'(adc_data);
                            val_valid <= 1'b1;
                            skip_cnt  <= decim_m1;
                            if (col_cnt == cols_m1) begin
                                state <= S_DONE;
                            end else begin
                                col_cnt <= col_cnt + COL_W'(1);
                            end
                        end else begin
                            skip_cnt <= skip_cnt - DECIM_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    capture_done <= 1'b1;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Randomized bench for scope_trigger_capture: a sample-list reference model predicts
// which valid samples become columns and when each val_valid strobe must appear.
module tb_scope_trigger_capture;

    localparam int ADC_RES = 12;
    localparam int VAL_RES = 16;
    localparam int DECIM_W = 16;
    localparam int COL_W   = 10;
    localparam int AUTO_TO = 20;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [ADC_RES-1:0] adc_data = '0;
    logic               adc_valid = 1'b0;
    logic               arm = 1'b0;
    logic [ADC_RES-1:0] trig_level = '0;
    logic [ADC_RES-1:0] trig_hyst = '0;
    logic               trig_slope = 1'b0;
    logic               auto_mode = 1'b0;
    logic [DECIM_W-1:0] decim = '0;
    logic [COL_W-1:0]   num_cols = '0;
    logic [VAL_RES-1:0] val;
    logic               val_valid;
    logic               capture_done;
    logic               busy;
    logic               auto_trig;

    scope_trigger_capture #(
        .ADC_RES      (ADC_RES),
        .VAL_RES      (VAL_RES),
        .DECIM_W      (DECIM_W),
        .COL_W        (COL_W),
        .AUTO_TIMEOUT (AUTO_TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .adc_data     (adc_data),
        .adc_valid    (adc_valid),
        .arm          (arm),
        .trig_level   (trig_level),
        .trig_hyst    (trig_hyst),
        .trig_slope   (trig_slope),
        .auto_mode    (auto_mode),
        .decim        (decim),
        .num_cols     (num_cols),
        .val          (val),
        .val_valid    (val_valid),
        .capture_done (capture_done),
        .busy         (busy),
        .auto_trig    (auto_trig)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Observed output events, sampled on the falling edge.
    int obs_val[$];
    int obs_cyc[$];
    int done_cyc[$];
    always @(negedge clk) begin
        if (!rst) begin
            if (val_valid) begin
                obs_val.push_back(int'(val));
                obs_cyc.push_back(cyc);
            end
            if (capture_done) done_cyc.push_back(cyc);
        end
    end

    // Stimulus per cycle after arm, and the valid samples actually presented.
    int st_data[$];
    bit st_valid[$];
    bit st_arm[$];
    int v_samp[$];
    int v_cyc[$];

    int c_level, c_hyst, c_slope, c_auto, c_decim, c_cols;

    int exp_val[$];
    int exp_cyc[$];
    bit exp_auto;
    bit exp_done;

    task automatic push(input int data, input bit valid, input bit a);
        st_data.push_back(data);
        st_valid.push_back(valid);
        st_arm.push_back(a);
    endtask

    task automatic set_cfg(input int lvl, input int hy, input int sl, input int au,
                           input int dc, input int nc);
        c_level = lvl; c_hyst = hy; c_slope = sl; c_auto = au; c_decim = dc; c_cols = nc;
        st_data.delete(); st_valid.delete(); st_arm.delete();
    endtask

    task automatic arm_dut();
        obs_val.delete(); obs_cyc.delete(); done_cyc.delete();
        v_samp.delete(); v_cyc.delete();
        @(negedge clk);
        trig_level = ADC_RES'(c_level);
        trig_hyst  = ADC_RES'(c_hyst);
        trig_slope = 1'(c_slope);
        auto_mode  = 1'(c_auto);
        decim      = DECIM_W'(c_decim);
        num_cols   = COL_W'(c_cols);
        adc_valid  = 1'b0;
        arm        = 1'b1;
    endtask

    // Expected columns: find the pre-arm sample, then the trigger (or timeout) sample,
    // then every decim-th valid sample after it.
    task automatic model();
        int lo, hi, d, n, pre, j;
        bit hit_real, hit_forced;
        lo = c_level - c_hyst;
        if (lo < 0) lo = 0;
        hi = c_level + c_hyst;
        if (hi > 4095) hi = 4095;
        d = (c_decim == 0) ? 1 : c_decim;
        n = (c_cols == 0) ? 1 : c_cols;
        exp_val.delete(); exp_cyc.delete();
        exp_auto = 1'b0; exp_done = 1'b0;
        pre = -1; j = -1;
        for (int i = 0; i < v_samp.size() && j < 0; i++) begin
            hit_real   = (pre >= 0) && (c_slope != 0 ? (v_samp[i] <= c_level) : (v_samp[i] >= c_level));
            hit_forced = (c_auto != 0) && (i == AUTO_TO - 1);
            if (hit_real || hit_forced) begin
                j = i;
                exp_auto = !hit_real;
            end else if (pre < 0 && (c_slope != 0 ? (v_samp[i] >= hi) : (v_samp[i] <= lo))) begin
                pre = i;
            end
        end
        if (j >= 0) begin
            for (int k = 0; k < n && j + k * d < v_samp.size(); k++) begin
                exp_val.push_back(v_samp[j + k * d]);
                exp_cyc.push_back(v_cyc[j + k * d] + 1);
            end
            exp_done = (exp_val.size() == n);
        end
    endtask

    // Arms, plays the stimulus queue (scrambling the config inputs to prove they were latched).
    task automatic run_capture(input int tail);
        arm_dut();
        for (int i = 0; i < st_data.size(); i++) begin
            @(negedge clk);
            arm        = st_arm[i];
            trig_level = ADC_RES'($urandom);
            trig_hyst  = ADC_RES'($urandom);
            trig_slope = 1'($urandom);
            auto_mode  = 1'($urandom);
            decim      = DECIM_W'($urandom);
            num_cols   = COL_W'($urandom);
            adc_data   = ADC_RES'(st_data[i]);
            adc_valid  = st_valid[i];
            if (st_valid[i]) begin
                v_samp.push_back(st_data[i]);
                v_cyc.push_back(cyc);
            end
        end
        @(negedge clk);
        arm = 1'b0;
        adc_valid = 1'b0;
        repeat (tail) @(negedge clk);
        model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        arm = 1'b0;
        adc_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (val !== '0) $display("FAIL reset_val: got %0d expected 0", val); else n_pass++;
        n_checks++; if (val_valid !== 1'b0) $display("FAIL reset_val_valid: got %b expected 0", val_valid); else n_pass++;
        n_checks++; if (capture_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", capture_done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (auto_trig !== 1'b0) $display("FAIL reset_auto_trig: got %b expected 0", auto_trig); else n_pass++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else n_pass++;
        $display("test_reset: outputs checked during and after reset");
    endtask

    task automatic test_rising();
        set_cfg(2048, 100, 0, 0, 1, 8);
        for (int i = 0; i < 64; i++) push(i * 64, 1'b1, 1'b0);
        run_capture(4);
        n_checks++; if (obs_val.size() != 8) $display("FAIL rising_count: got %0d expected 8", obs_val.size()); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (k >= obs_val.size() || obs_val[k] != 2048 + 64 * k || obs_cyc[k] != exp_cyc[k])
                $display("FAIL rising_col%0d: got %0d@%0d expected %0d@%0d", k,
                         (k < obs_val.size()) ? obs_val[k] : -1, (k < obs_cyc.size()) ? obs_cyc[k] : -1,
                         2048 + 64 * k, exp_cyc[k]);
            else n_pass++;
        end
        n_checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != exp_cyc[7] + 1)
            $display("FAIL rising_done: got %0d pulses first@%0d expected 1@%0d", done_cyc.size(),
                     (done_cyc.size() > 0) ? done_cyc[0] : -1, exp_cyc[7] + 1);
        else n_pass++;
        n_checks++; if (auto_trig !== 1'b0) $display("FAIL rising_auto_trig: got %b expected 0", auto_trig); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rising_busy: got %b expected 0", busy); else n_pass++;
        $display("test_rising: %0d columns observed", obs_val.size());
    endtask

    task automatic test_hysteresis();
        set_cfg(2048, 100, 0, 0, 1, 4);
        for (int i = 0; i < 30; i++) push($urandom_range(2100, 1990), 1'b1, 1'b0);
        push(1900, 1'b1, 1'b0);
        push(2048, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) push($urandom_range(4095, 0), 1'b1, 1'b0);
        run_capture(4);
        n_checks++;
        if (obs_val.size() == 0 || obs_val[0] != 2048 || obs_cyc[0] != v_cyc[31] + 1)
            $display("FAIL hyst_first: got %0d@%0d expected 2048@%0d",
                     (obs_val.size() > 0) ? obs_val[0] : -1, (obs_cyc.size() > 0) ? obs_cyc[0] : -1, v_cyc[31] + 1);
        else n_pass++;
        n_checks++;
        if (obs_val != exp_val || obs_cyc != exp_cyc)
            $display("FAIL hyst_columns: got %0d cols expected %0d", obs_val.size(), exp_val.size());
        else n_pass++;
        n_checks++; if (done_cyc.size() != 1) $display("FAIL hyst_done: got %0d pulses expected 1", done_cyc.size()); else n_pass++;
        $display("test_hysteresis: trigger at cycle %0d", (obs_cyc.size() > 0) ? obs_cyc[0] : -1);
    endtask

    task automatic test_decimation();
        set_cfg(10, 2, 0, 0, 4, 3);
        for (int v = 0; v < 30; v++) begin
            push(v, 1'b1, 1'b0);
            push($urandom_range(4095, 0), 1'b0, 1'b0);
            push($urandom_range(4095, 0), 1'b0, 1'b0);
        end
        run_capture(4);
        n_checks++; if (obs_val.size() != 3) $display("FAIL decim_count: got %0d expected 3", obs_val.size()); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (k >= obs_val.size() || obs_val[k] != 10 + 4 * k || obs_cyc[k] != exp_cyc[k])
                $display("FAIL decim_col%0d: got %0d@%0d expected %0d@%0d", k,
                         (k < obs_val.size()) ? obs_val[k] : -1, (k < obs_cyc.size()) ? obs_cyc[k] : -1,
                         10 + 4 * k, exp_cyc[k]);
            else n_pass++;
        end
        n_checks++;
        if (done_cyc.size() != 1 || done_cyc[0] != exp_cyc[2] + 1)
            $display("FAIL decim_done: got %0d pulses expected 1@%0d", done_cyc.size(), exp_cyc[2] + 1);
        else n_pass++;
        $display("test_decimation: %0d columns observed", obs_val.size());
    endtask

    task automatic test_auto();
        // Forced trigger on the timeout sample.
        set_cfg(2048, 100, 0, 1, 1, 4);
        for (int i = 0; i < 30; i++) begin
            push(500, 1'b1, 1'b0);
            if ($urandom_range(3, 0) == 0) push($urandom_range(4095, 0), 1'b0, 1'b0);
        end
        run_capture(4);
        n_checks++;
        if (obs_cyc.size() == 0 || obs_cyc[0] != v_cyc[AUTO_TO - 1] + 1)
            $display("FAIL auto_start: got @%0d expected @%0d",
                     (obs_cyc.size() > 0) ? obs_cyc[0] : -1, v_cyc[AUTO_TO - 1] + 1);
        else n_pass++;
        n_checks++; if (obs_val != exp_val) $display("FAIL auto_columns: got %0d cols expected %0d", obs_val.size(), exp_val.size()); else n_pass++;
        n_checks++; if (auto_trig !== 1'b1 || !exp_auto) $display("FAIL auto_flag: got %b expected 1", auto_trig); else n_pass++;
        $display("test_auto: forced capture, auto_trig=%b", auto_trig);

        // Real edge on the very sample the timeout expires: the edge wins.
        set_cfg(2048, 100, 0, 1, 1, 4);
        for (int i = 0; i < 30; i++) push((i == AUTO_TO - 1) ? 2048 : 500, 1'b1, 1'b0);
        run_capture(4);
        n_checks++;
        if (obs_val.size() == 0 || obs_val[0] != 2048 || obs_cyc[0] != v_cyc[AUTO_TO - 1] + 1)
            $display("FAIL auto_tie_start: got %0d@%0d expected 2048@%0d",
                     (obs_val.size() > 0) ? obs_val[0] : -1, (obs_cyc.size() > 0) ? obs_cyc[0] : -1, v_cyc[AUTO_TO - 1] + 1);
        else n_pass++;
        n_checks++; if (auto_trig !== exp_auto) $display("FAIL auto_tie_flag: got %b expected %b", auto_trig, exp_auto); else n_pass++;
        $display("test_auto: tie resolved, auto_trig=%b", auto_trig);

        // Without auto mode a flat input never triggers.
        set_cfg(2048, 100, 0, 0, 1, 4);
        for (int i = 0; i < 40; i++) push(500, 1'b1, 1'b0);
        run_capture(4);
        n_checks++; if (obs_val.size() != 0) $display("FAIL noauto_cols: got %0d expected 0", obs_val.size()); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL noauto_busy: got %b expected 1", busy); else n_pass++;
        $display("test_auto: no-auto run, busy=%b", busy);
    endtask

    task automatic test_falling_zero();
        set_cfg(1000, 0, 1, 0, 0, 0);
        push(1500, 1'b1, 1'b0);
        for (int i = 0; i < 25; i++) push($urandom_range(2047, 0), ($urandom_range(3, 0) != 0), 1'b0);
        push(10, 1'b1, 1'b0);
        push(10, 1'b1, 1'b0);
        run_capture(4);
        n_checks++; if (obs_val.size() != 1) $display("FAIL fall_count: got %0d expected 1", obs_val.size()); else n_pass++;
        n_checks++;
        if (obs_val.size() == 0 || obs_val[0] > 1000 || obs_val != exp_val || obs_cyc != exp_cyc)
            $display("FAIL fall_value: got %0d expected %0d", (obs_val.size() > 0) ? obs_val[0] : -1,
                     (exp_val.size() > 0) ? exp_val[0] : -1);
        else n_pass++;
        n_checks++;
        if (done_cyc.size() != 1 || exp_cyc.size() == 0 || done_cyc[0] != exp_cyc[0] + 1)
            $display("FAIL fall_done: got %0d pulses expected 1", done_cyc.size());
        else n_pass++;

        // lo saturates to 0: only a true zero pre-arms.
        set_cfg(50, 100, 0, 0, 0, 1);
        push(1, 1'b1, 1'b0); push(5, 1'b1, 1'b0); push(1, 1'b1, 1'b0);
        push(60, 1'b1, 1'b0); push(0, 1'b1, 1'b0); push(60, 1'b1, 1'b0);
        push(3000, 1'b1, 1'b0);
        run_capture(4);
        n_checks++;
        if (obs_val.size() != 1 || obs_val[0] != 60 || obs_cyc[0] != v_cyc[5] + 1)
            $display("FAIL lo_sat: got %0d cols first@%0d expected 1@%0d", obs_val.size(),
                     (obs_cyc.size() > 0) ? obs_cyc[0] : -1, v_cyc[5] + 1);
        else n_pass++;

        // hi saturates to full scale on the falling slope.
        set_cfg(4000, 200, 1, 0, 1, 1);
        push(4094, 1'b1, 1'b0); push(3000, 1'b1, 1'b0); push(4095, 1'b1, 1'b0);
        push(3990, 1'b1, 1'b0); push(100, 1'b1, 1'b0);
        run_capture(4);
        n_checks++;
        if (obs_val.size() != 1 || obs_val[0] != 3990 || obs_cyc != exp_cyc)
            $display("FAIL hi_sat: got %0d cols first %0d expected 1 of 3990", obs_val.size(),
                     (obs_val.size() > 0) ? obs_val[0] : -1);
        else n_pass++;
        $display("test_falling_zero: single-column and saturation cases done");
    endtask

    task automatic test_reset_mid();
        bit reached;
        reached = 1'b0;
        set_cfg(2048, 100, 0, 0, 1, 8);
        arm_dut();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            arm = 1'b0;
            adc_data = ADC_RES'(i * 64);
            adc_valid = 1'b1;
            #1;
            if (obs_val.size() == 3) begin
                reached = 1'b1;
                break;
            end
        end
        n_checks++; if (!reached) $display("FAIL rstmid_reach: got %0d cols expected 3", obs_val.size()); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({val, val_valid, capture_done, busy, auto_trig} !== '0)
            $display("FAIL rstmid_async: got val=%0d vv=%b done=%b busy=%b expected all 0", val, val_valid, capture_done, busy);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        adc_valid = 1'b0;
        n_checks++;
        if (done_cyc.size() != 0 || obs_val.size() != 3 || busy !== 1'b0)
            $display("FAIL rstmid_after: got done=%0d cols=%0d busy=%b expected 0/3/0", done_cyc.size(), obs_val.size(), busy);
        else n_pass++;
        $display("test_reset_mid: capture aborted after %0d columns", obs_val.size());
    endtask

    task automatic test_arm_ignore();
        set_cfg(2048, 100, 0, 0, 2, 8);
        for (int i = 0; i < 64; i++) push(i * 64, 1'b1, (i == 5 || i == 36 || i == 40 || i == 44));
        run_capture(10);
        n_checks++;
        if (obs_val != exp_val || obs_cyc != exp_cyc || obs_val.size() != 8)
            $display("FAIL armign_columns: got %0d cols expected 8", obs_val.size());
        else n_pass++;
        n_checks++; if (done_cyc.size() != 1) $display("FAIL armign_done: got %0d pulses expected 1", done_cyc.size()); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL armign_busy: got %b expected 0", busy); else n_pass++;
        $display("test_arm_ignore: %0d columns, %0d done pulses", obs_val.size(), done_cyc.size());
    endtask

    initial begin
        test_reset();
        test_rising();
        test_hysteresis();
        test_decimation();
        test_auto();
        do_reset();
        test_falling_zero();
        test_reset_mid();
        do_reset();
        test_arm_ignore();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
